// File: rtl/jk_exc_pkg.sv
// Shared types and constants for the JK excitation driver.
// No logic of its own: state encoding and per-bit {J,K} codes.
// No flow control here; see jk_excitation_driver for the handshake.
package jk_exc_pkg;

    // Driver FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } jk_drv_state_t;

    // Per-bit excitation codes, packed as {J, K}.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// Purpose: per-bit J/K excitation that moves a JK bank from cur to tgt.
// Latency: purely combinational. Optional build macro: JK_EXC_TOGGLE_EN.
// Backpressure: none; the caller decides when the result is driven.
module jk_excite
    import jk_exc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] code;

        // Equal bits hold; differing bits either toggle or get an explicit set/reset.
        always_comb begin
            code = JK_HOLD;
            if (cur[i] != tgt[i]) begin
`ifdef JK_EXC_TOGGLE_EN
                code = JK_TGL;
`else
                code = tgt[i] ? JK_SET : JK_RST;
`endif
            end
        end

        assign j[i] = code[1];
        assign k[i] = code[0];
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Purpose: drive one J/K excitation pulse toward a target word, settle, read back, retry on mismatch.
// Latency: accept to done/err = (SETTLE+2) cycles per attempt. Build macro JK_EXC_TOGGLE_EN selects toggle encoding.
// Backpressure: tgt_ready is high only while idle (including the done/err cycle); offers while busy are ignored.
module jk_excitation_driver
    import jk_exc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2,
    localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RW-1:0]    retry_cnt
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

    if (SETTLE < 1) begin : g_settle_chk
        $error("jk_excitation_driver: SETTLE must be >= 1");
    end

    jk_drv_state_t    state, state_nxt;
    logic [WIDTH-1:0] tgt_q, tgt_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic [WIDTH-1:0] exc_j, exc_k, exc_tgt;
    logic [SW-1:0]    settle_cnt, settle_nxt;
    logic [RW-1:0]    retry_nxt;
    logic             done_nxt, err_nxt;

    // J/K are registered, so excitation is computed in the cycle before DRIVE:
    // from the offered word on accept, from the latched target on a retry.
    // The bank cannot move while J=K=0, so q_in then equals q during DRIVE.
    assign exc_tgt = (state == ST_IDLE) ? tgt_data : tgt_q;

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .cur (q_in),
        .tgt (exc_tgt),
        .j   (exc_j),
        .k   (exc_k)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt_q;
        retry_nxt  = retry_cnt;
        settle_nxt = settle_cnt;
        j_nxt      = '0;
        k_nxt      = '0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tgt_valid && tgt_ready) begin
                    tgt_nxt   = tgt_data;
                    retry_nxt = '0;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                settle_nxt = SETTLE_LD;
                state_nxt  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = ST_CHECK;
                end else begin
                    settle_nxt = settle_cnt - 1'b1;
                end
            end
            ST_CHECK: begin
                if (q_in == tgt_q) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (retry_cnt < RETRY_LIM) begin
                    retry_nxt = retry_cnt + 1'b1;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    state_nxt = ST_DRIVE;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            tgt_q      <= '0;
            retry_cnt  <= '0;
            settle_cnt <= '0;
            j_out      <= '0;
            k_out      <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            tgt_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            tgt_q      <= tgt_nxt;
            retry_cnt  <= retry_nxt;
            settle_cnt <= settle_nxt;
            j_out      <= j_nxt;
            k_out      <= k_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            busy       <= (state_nxt != ST_IDLE);
            tgt_ready  <= (state_nxt == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: JK bank model with injectable non-response,
// scoreboard queue filled at issue time, monitor checks each done/err.
module tb_jk_excitation_driver;

    localparam int W  = 8;
    localparam int ST = 1;
    localparam int MR = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tgt_valid = 1'b0;
    logic         tgt_ready;
    logic [W-1:0] tgt_data = '0;
    logic [W-1:0] j_out, k_out;
    logic         busy, done, err;
    logic [1:0]   retry_cnt;

    // JK bank model state
    logic [W-1:0] q_bank = '0;
    logic [W-1:0] bank_nq;
    logic [W-1:0] ign_mask = '0;
    int           ign_upto = 0;
    int           drive_cnt = 0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic [W-1:0] q;
        logic         ok;
        int           retries;
        int           lat;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] qm = '0;

    jk_excitation_driver #(.WIDTH(W), .SETTLE(ST), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_in      (q_bank),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // Bank: JK semantics per bit; masked bits ignore the first few non-idle excitations.
    always_comb begin
        bank_nq = q_bank;
        for (int i = 0; i < W; i++) begin
            case ({j_out[i], k_out[i]})
                2'b01:   bank_nq[i] = 1'b0;
                2'b10:   bank_nq[i] = 1'b1;
                2'b11:   bank_nq[i] = ~q_bank[i];
                default: bank_nq[i] = q_bank[i];
            endcase
        end
        if (drive_cnt < ign_upto) bank_nq = (bank_nq & ~ign_mask) | (q_bank & ign_mask);
    end

    always @(posedge clk) begin
        if ((j_out | k_out) != '0) begin
            q_bank    <= bank_nq;
            drive_cnt <= drive_cnt + 1;
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
        end
    endfunction

    // Reference: outcome of a transfer from the bank state and the fault injected.
    function automatic exp_t model(input logic [W-1:0] q0, input logic [W-1:0] t,
                                   input logic [W-1:0] m, input int n);
        exp_t         e;
        logic [W-1:0] d;
        int           attempts;
        d = q0 ^ t;
`ifdef JK_EXC_TOGGLE_EN
        e.j = d;
        e.k = d;
`else
        e.j = t & ~q0;
        e.k = ~t & q0;
`endif
        if ((d & m) == '0 || n == 0) begin
            attempts = 1;
            e.ok = 1'b1;
        end else if (n <= MR) begin
            attempts = n + 1;
            e.ok = 1'b1;
        end else begin
            attempts = MR + 1;
            e.ok = 1'b0;
        end
        e.q       = e.ok ? t : ((t & ~m) | (q0 & m));
        e.retries = attempts - 1;
        e.lat     = attempts * (ST + 2);
        return e;
    endfunction

    task automatic summary_and_fatal(input string why);
        errors++;
        checks++;
        $display("FAIL %s: bound expired", why);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "aborting");
    endtask

    task automatic wait_ready();
        int w = 0;
        while (tgt_ready !== 1'b1) begin
            @(posedge clk); #1;
            w++;
            if (w > 500) summary_and_fatal("timeout_ready");
        end
    endtask

    task automatic send(input logic [W-1:0] t, input logic [W-1:0] m, input int n);
        exp_t e;
        wait_ready();
        e = model(qm, t, m, n);
        exp_q.push_back(e);
        qm = e.q;
        ign_mask = m;
        ign_upto = drive_cnt + n;
        tgt_data  = t;
        tgt_valid = 1'b1;
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        tgt_data  = W'($urandom);
    endtask

    // Monitor: pops the scoreboard on every done/err and checks the whole transfer.
    initial begin
        int           cyc = 0;
        int           acc_cyc = 0;
        logic         pend = 1'b0;
        logic [W-1:0] cap_j = '0, cap_k = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cap_j = j_out;
                    cap_k = k_out;
                    pend  = 1'b0;
                end
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: done=%0b err=%0b with nothing pending", done, err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done", 32'(done), 32'(e.ok));
                        chk("err", 32'(err), 32'(!e.ok));
                        chk("retry_cnt", 32'(retry_cnt), e.retries);
                        chk("latency", cyc - acc_cyc - 1, e.lat);
                        chk("bank_q", 32'(q_bank), 32'(e.q));
                        chk("drive_j", 32'(cap_j), 32'(e.j));
                        chk("drive_k", 32'(cap_k), 32'(e.k));
                        chk("ready_at_done", 32'(tgt_ready), 32'd1);
                    end
                end
`ifndef JK_EXC_TOGGLE_EN
                if ((j_out & k_out) != '0) chk("no_toggle_code", 32'(j_out & k_out), 32'd0);
`endif
                if (tgt_valid && tgt_ready) begin
                    acc_cyc = cyc;
                    pend    = 1'b1;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int   w;
        int   hits;
        exp_t ea, eb;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(tgt_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_j", 32'(j_out), 32'd0);
        chk("rst_k", 32'(k_out), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_retry", 32'(retry_cnt), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed transfers
        send(8'hA5, 8'h00, 0);
        send(8'hF0, 8'h00, 0);
        send(8'h0F, 8'h00, 0);
        send(8'h3C, 8'h00, 0);
        send(8'h3C, 8'h00, 0);          // already at target
        send(8'h00, 8'h00, 0);
        send(8'h01, 8'h01, 2);          // bit 0 lags two drives -> two retries
        send(8'h00, 8'h00, 0);
        send(8'h01, 8'h01, 1000);       // bit 0 stuck -> err after three drives

        // Reset during SETTLE aborts the transfer; the DRIVE edge still updated the bank.
        wait_ready();
        ign_upto  = drive_cnt;
        qm        = 8'h5A;
        tgt_data  = 8'h5A;
        tgt_valid = 1'b1;
        @(posedge clk); #1;             // DRIVE
        tgt_valid = 1'b0;
        @(posedge clk); #1;             // SETTLE
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 32'(tgt_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_jk", 32'({j_out, k_out}), 32'd0);
        chk("abort_done_err", 32'({done, err}), 32'd0);
        reset = 1'b1;
        hits = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done || err) hits++;
        end
        chk("abort_no_completion", hits, 0);
        chk("abort_bank_q", 32'(q_bank), 32'h5A);

        // Back-to-back: valid held with new data while busy; second accepted in done cycle.
        wait_ready();
        ign_upto = drive_cnt;
        ea = model(qm, 8'hC3, 8'h00, 0);
        eb = model(ea.q, 8'h18, 8'h00, 0);
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        qm = eb.q;
        tgt_data  = 8'hC3;
        tgt_valid = 1'b1;
        @(posedge clk); #1;
        tgt_data = 8'h18;
        w = 0;
        while (tgt_ready !== 1'b1) begin
            @(posedge clk); #1;
            w++;
            if (w > 50) summary_and_fatal("timeout_b2b");
        end
        chk("b2b_accept_in_done_cycle", 32'(done), 32'd1);
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        tgt_data  = 8'h77;

        // Random targets with occasional lagging bits
        for (int r = 0; r < 30; r++) begin
            logic [W-1:0] t, m;
            t = W'($urandom);
            m = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            send(t, m, int'($urandom_range(0, 4)));
        end

        // Drain the scoreboard
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
